// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the request-master FSM state type.
`timescale 1ns/1ps
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester
// and only moves when the owner accepts the grant.
`timescale 1ns/1ps
module rr_arbiter2 #(
   parameter bit RESET_PRIO = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic [1:0] grant_o
);

   logic last_q, last_d;

   always_comb begin
      grant_o = 2'b00;
      unique case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   assign last_d = (update_i && (grant_o != 2'b00)) ? grant_o[1] : last_q;

   // Reset pretends the other requester went last so RESET_PRIO wins first contention.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) last_q <= ~RESET_PRIO;
      else         last_q <= last_d;
   end

endmodule

// File: rtl/ahb_req_arbiter_master.sv
// Two-port AHB-Lite master: round-robin picks a port, issues one single-word
// NONSEQ transfer, and returns a one-cycle ack with rdata/err to that port.
`timescale 1ns/1ps
module ahb_req_arbiter_master
   import ahb_lite_pkg::*;
#(
   parameter bit ALIGN_CHECK = 1'b1,
   parameter bit RESET_PRIO  = 1'b0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        req0_valid,
   input  logic        req0_write,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_ack,
   output logic [31:0] req0_rdata,
   output logic        req0_err,
   input  logic        req1_valid,
   input  logic        req1_write,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_ack,
   output logic [31:0] req1_rdata,
   output logic        req1_err,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [1:0]  HTRANS,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   state_e           state_q, state_d;
   logic [1:0]       req, grant;
   logic             take, sel, sel_write, sel_unaligned;
   logic [31:0]      sel_addr, sel_wdata;
   logic             gnt_q, gnt_d;
   logic [31:0]      cmd_wdata_q;
   logic [1:0]       htrans_q, htrans_d;
   logic [31:0]      haddr_q, haddr_d;
   logic             hwrite_q, hwrite_d;
   logic [31:0]      hwdata_q, hwdata_d;
   logic [1:0]       ack_q, ack_d;
   logic [1:0]       err_q, err_d;
   logic [1:0][31:0] rdata_q, rdata_d;

   assign req  = {req1_valid, req0_valid};
   assign take = (state_q == ST_IDLE) && (req != 2'b00);

   rr_arbiter2 #(.RESET_PRIO(RESET_PRIO)) u_arb (
      .clk_i    (HCLK),
      .rst_ni   (HRESETn),
      .req_i    (req),
      .update_i (take),
      .grant_o  (grant)
   );

   assign sel           = grant[1];
   assign sel_write     = sel ? req1_write : req0_write;
   assign sel_addr      = sel ? req1_addr  : req0_addr;
   assign sel_wdata     = sel ? req1_wdata : req0_wdata;
   assign sel_unaligned = ALIGN_CHECK && !is_word_aligned(sel_addr);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // RESP always follows a completion so a valid still high during ack is not re-sampled.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (take)   state_d = sel_unaligned ? ST_RESP : ST_ADDR;
         ST_ADDR: if (HREADY) state_d = ST_DATA;
         ST_DATA: if (HREADY) state_d = ST_RESP;
         ST_RESP:             state_d = ST_IDLE;
         default:             state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      htrans_d = htrans_q;
      haddr_d  = haddr_q;
      hwrite_d = hwrite_q;
      hwdata_d = hwdata_q;
      gnt_d    = gnt_q;
      ack_d    = 2'b00;
      err_d    = err_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (take) begin
               gnt_d = sel;
               if (sel_unaligned) begin
                  ack_d[sel] = 1'b1;
                  err_d[sel] = 1'b1;
               end else begin
                  htrans_d = HTRANS_NONSEQ;
                  haddr_d  = {sel_addr[31:2], 2'b00};
                  hwrite_d = sel_write;
               end
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               htrans_d = HTRANS_IDLE;
               hwdata_d = cmd_wdata_q;
            end
         end
         ST_DATA: begin
            // The first ERROR cycle arrives with HREADY low and is just a wait.
            if (HREADY) begin
               ack_d[gnt_q] = 1'b1;
               err_d[gnt_q] = HRESP;
               if (!hwrite_q && (HRESP == HRESP_OKAY)) rdata_d[gnt_q] = HRDATA;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         gnt_q    <= 1'b0;
         htrans_q <= HTRANS_IDLE;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         hwdata_q <= '0;
         ack_q    <= '0;
         err_q    <= '0;
         rdata_q  <= '0;
      end else begin
         gnt_q    <= gnt_d;
         htrans_q <= htrans_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         hwdata_q <= hwdata_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (take) cmd_wdata_q <= sel_wdata;
   end

   assign HTRANS     = htrans_q;
   assign HADDR      = haddr_q;
   assign HWRITE     = hwrite_q;
   assign HWDATA     = hwdata_q;
   assign HSIZE      = HSIZE_WORD;
   assign req0_ack   = ack_q[0];
   assign req1_ack   = ack_q[1];
   assign req0_err   = err_q[0];
   assign req1_err   = err_q[1];
   assign req0_rdata = rdata_q[0];
   assign req1_rdata = rdata_q[1];

endmodule
